sram_i_reader: RTL

Streaming read engine on the read side of the 3136 x 145-bit input-feature SRAM. On a start pulse it sweeps a programmed address window, absorbs the SRAM's one-cycle registered read latency, and delivers the words in order as a valid/ready stream to the convolution datapath. A small credit-controlled FIFO lets the consumer stall without losing in-flight reads. Sustained throughput is one word per cycle.

---
 rtl/sram_i_reader.sv | 122 ++++++++++++
 1 files changed

// File: rtl/sram_i_reader.sv
// Streaming read engine: sweeps an SRAM address window and delivers the words in order
// on a valid/ready stream, with a small credit-controlled FIFO that absorbs consumer stalls.
module sram_i_reader #(
  parameter int WORD_AMOUNT  = 3136,
  parameter int BIT_PER_WORD = 145,
  parameter int AW           = $clog2(WORD_AMOUNT),
  parameter int CW           = $clog2(WORD_AMOUNT+1),
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [AW-1:0]           start_addr,
  input  logic [CW-1:0]           word_count,
  output logic                    busy,
  output logic                    done,
  output logic [AW-1:0]           sram_addr,
  input  logic [BIT_PER_WORD-1:0] sram_dout,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BIT_PER_WORD-1:0] out_data,
  output logic                    out_last
);
  localparam int STAGES = 2;
  localparam int PW     = $clog2(FIFO_DEPTH);
  localparam int FCW    = $clog2(FIFO_DEPTH+1);
  localparam int OW     = FCW + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_nxt;

  logic [STAGES:1]         vld_pipe, last_pipe;
  logic [CW-1:0]           remaining;
  logic [AW-1:0]           addr_nxt;
  logic [FCW-1:0]          fifo_count;
  logic [1:0]              inflight;
  logic [OW-1:0]           occ;
  logic                    credit_ok, issue, issue_last, push, pop, zero_done;
  logic [BIT_PER_WORD-1:0] fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]   fifo_last;
  logic [PW-1:0]           wr_ptr, rd_ptr;

  // Credits cover both buffered words and reads still in the SRAM pipeline,
  // so the FIFO can never overflow and the SRAM never needs backpressure.
  assign inflight  = {1'b0, vld_pipe[1]} + {1'b0, vld_pipe[2]};
  assign occ       = OW'(fifo_count) + OW'(inflight);
  assign credit_ok = occ < OW'(FIFO_DEPTH);

  assign push      = vld_pipe[2];
  assign out_valid = fifo_count != '0;
  assign pop       = out_valid & out_ready;
  assign out_data  = fifo_data[rd_ptr];
  assign out_last  = out_valid & fifo_last[rd_ptr];
  assign busy      = state != IDLE;
  assign done      = zero_done | (pop & out_last);

  always_comb begin
    if (state == IDLE)                        addr_nxt = start_addr;
    else if (sram_addr == AW'(WORD_AMOUNT-1)) addr_nxt = '0;
    else                                      addr_nxt = sram_addr + AW'(1);
  end

  always_comb begin
    state_nxt  = state;
    issue      = 1'b0;
    issue_last = 1'b0;
    case (state)
      IDLE: if (start && word_count != '0) begin
        issue      = 1'b1;
        issue_last = word_count == CW'(1);
        state_nxt  = issue_last ? DRAIN : RUN;
      end
      RUN: if (credit_ok) begin
        issue      = 1'b1;
        issue_last = remaining == CW'(1);
        if (issue_last) state_nxt = DRAIN;
      end
      DRAIN: if (pop && out_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe   <= '0;
      last_pipe  <= '0;
      remaining  <= '0;
      sram_addr  <= '0;
      zero_done  <= 1'b0;
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_last  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_data[i] <= '0;
    end else begin
      vld_pipe  <= {vld_pipe[1], issue};
      last_pipe <= {last_pipe[1], issue_last};
      zero_done <= (state == IDLE) && start && (word_count == '0);
      if (issue) begin
        sram_addr <= addr_nxt;
        remaining <= ((state == IDLE) ? word_count : remaining) - CW'(1);
      end
      // Data stage: the SRAM output now belongs to the read issued two edges ago.
      if (push) begin
        fifo_data[wr_ptr] <= sram_dout;
        fifo_last[wr_ptr] <= last_pipe[2];
        wr_ptr            <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + FCW'(1);
        2'b01:   fifo_count <= fifo_count - FCW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end
endmodule
